pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the RV32I core: holds the architectural fetch PC in a register, presents it to instruction fetch through a valid/ready handshake, and resolves control-flow redirects from execute. Supports all six conditional branch types, JAL and JALR, a halt request, and optional misaligned-target trapping. Sits between the execute stage (redirect source) and the instruction-fetch interface.

## Interface
- XLEN, 32, datapath and PC width
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_ready  in  1  fetch accepts current pc
- halt_req  in  1  level request to stop issuing fetches
- ex_valid  in  1  execute presents a resolved instruction this cycle
- ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  instruction class (one-hot or all zero)
- ex_funct3  in  3  branch condition code
- ex_zero / ex_lt / ex_ltu  in  1 each  ALU flags: rs1==rs2, signed rs1<rs2, unsigned rs1<rs2
- ex_pc  in  XLEN  PC of the execute instruction
- ex_imm  in  XLEN  sign-extended B/J/I immediate
- ex_rs1  in  XLEN  rs1 value (JALR base)
- pc  out  XLEN  current fetch PC
- fetch_valid  out  1  pc is a valid fetch request
- redirect  out  1  control flow changed this cycle (flush younger stages)
- link_addr  out  XLEN  ex_pc+4, combinational, for rd of JAL/JALR
- misalign_exc  out  1  one-cycle pulse: taken target misaligned (macro only)
- bad_addr  out  XLEN  offending target, held until next exception

## Operation
- FSM states: BOOT, RUN, HALT.
- BOOT: entered on reset; fetch_valid=0; goes to RUN next clock (HALT if halt_req=1).
- RUN: fetch_valid=1; pc <= pc+4 when fetch_valid&&fetch_ready and no redirect; halt_req=1 -> HALT (pc held).
- HALT: fetch_valid=0; pc held; halt_req=0 -> RUN.
- Taken decision (ex_valid=1): JAL, JALR always taken; branch taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 never taken.
- Target: branch/JAL = ex_pc+ex_imm; JALR = (ex_rs1+ex_imm) & ~1. All sums modulo 2^XLEN (wrap, no carry out).
- Taken: redirect=1 combinationally, pc <= target next edge in any state except BOOT; state unchanged (redirect in HALT updates pc, stays halted).
- Priority per cycle: reset > misalign trap > redirect > halt transition > sequential advance.
- Not-taken or ex_valid=0: redirect=0, no effect on pc.
- link_addr computed regardless of ex_valid.

## Timing
- Reset (async): pc=RESET_VECTOR, state=BOOT, fetch_valid=0, redirect=0, misalign_exc=0, bad_addr=0.
- First fetch_valid=1 one cycle after rst_n rises (BOOT -> RUN).
- Redirect latency: 1 cycle (target on pc the edge after taken ex_valid); redirect overrides a simultaneous fetch handshake — the accepted pc is not incremented.
- fetch_ready=0 holds pc and fetch_valid stable (no dropped request).
- redirect and misalign_exc are combinational from ex_* inputs, no registered state.
- Reset asserted mid-operation: all outputs return to reset values immediately.

## Configuration
- PC_MISALIGN_TRAP_EN defined: taken target with target[1]=1 (bit 0 already cleared for JALR; bit 0 set for branch/JAL also faults) raises misalign_exc=1, bad_addr <= target, pc <= TRAP_VECTOR next edge, redirect=1.
- Undefined: no trap; target[1:0] forced to 00; misalign_exc tied 0, bad_addr tied 0.

## Test plan
- Reset, release, fetch_ready=1 constant -> fetch_valid 0 one cycle, then pc 0x0,0x4,0x8 on successive cycles.
- fetch_ready=0 for 3 cycles at pc=0x8 -> pc stays 0x8, fetch_valid=1; resume -> 0xC.
- BEQ ex_pc=0x40, ex_imm=-16, zero=1 -> redirect=1, next pc=0x30; same with zero=0 -> no redirect, sequential.
- JALR ex_rs1=0x1001, ex_imm=4 -> pc=0x1004, link_addr=ex_pc+4; funct3=010 branch -> never taken.
- halt_req=1 in RUN -> fetch_valid=0, pc held; redirect to 0x200 while halted -> pc=0x200, still halted; release -> fetches 0x200.
- With PC_MISALIGN_TRAP_EN: JAL ex_pc=0x10, ex_imm=6 -> misalign_exc pulse, bad_addr=0x16, pc=TRAP_VECTOR; without macro -> pc=0x14.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the RV32I core.
// Holds the architectural fetch PC, offers it to instruction fetch through a
// valid/ready handshake and applies control-flow redirects resolved in execute.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap on misaligned taken
// targets (pc <= TRAP_VECTOR, bad_addr captured). Without it, taken targets
// are word-aligned by clearing bits [1:0], misalign_exc and bad_addr read 0.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready,
  input  logic            halt_req,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_zero,
  input  logic            ex_lt,
  input  logic            ex_ltu,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            redirect,
  output logic [XLEN-1:0] link_addr,
  output logic            misalign_exc,
  output logic [XLEN-1:0] bad_addr
);

  // BOOT is a one-cycle quiet period after reset; RUN issues fetches;
  // HALT parks the PC until the halt request drops.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            cond_true;
  logic            taken;
  logic            ctrl_active;
  logic            redirect_hit;
  logic            misalign_hit;
  logic [XLEN-1:0] target_base;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target_pc;
  logic            fetch_fire;

  // Branch condition from the ALU flags; 010/011 are not branch encodings.
  always_comb begin
    cond_true = 1'b0;
    unique case (ex_funct3)
      3'b000:  cond_true = ex_zero;   // BEQ
      3'b001:  cond_true = ~ex_zero;  // BNE
      3'b100:  cond_true = ex_lt;     // BLT
      3'b101:  cond_true = ~ex_lt;    // BGE
      3'b110:  cond_true = ex_ltu;    // BLTU
      3'b111:  cond_true = ~ex_ltu;   // BGEU
      default: cond_true = 1'b0;
    endcase
  end

  // Taken decision and raw target; JALR adds to rs1 and drops bit 0.
  always_comb begin
    taken       = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond_true));
    target_base = ex_is_jalr ? ex_rs1 : ex_pc;
    raw_target  = target_base + ex_imm;
    if (ex_is_jalr) begin
      raw_target[0] = 1'b0;
    end
  end

  // Redirects are ignored during BOOT so reset keeps every output quiet
  // even while execute still drives a stale taken instruction.
  assign ctrl_active  = (state_q != ST_BOOT);
  assign redirect_hit = ctrl_active & taken;

`ifdef PC_MISALIGN_TRAP_EN
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;

  // Any taken target that is not word aligned diverts to the trap vector.
  always_comb begin
    misalign_hit = redirect_hit & (raw_target[1] | raw_target[0]);
    target_pc    = raw_target;
  end

  // Capture the offending target; otherwise keep the last one.
  always_comb begin
    bad_addr_d = bad_addr_q;
    if (misalign_hit) begin
      bad_addr_d = raw_target;
    end
  end

  // Faulting-address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_addr_q <= '0;
    end else begin
      bad_addr_q <= bad_addr_d;
    end
  end

  assign bad_addr     = bad_addr_q;
  assign misalign_exc = misalign_hit;
`else
  // No trapping: force word alignment of every taken target.
  always_comb begin
    misalign_hit = 1'b0;
    target_pc    = raw_target & ~XLEN'(3);
  end

  assign bad_addr     = '0;
  assign misalign_exc = 1'b0;
`endif

  // A fetch is consumed only while RUN presents it and fetch accepts it.
  assign fetch_fire = (state_q == ST_RUN) & fetch_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect (or trap) leaves the state untouched,
  // so halt transitions wait for a cycle without a redirect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = halt_req ? ST_HALT : ST_RUN;
      ST_RUN: begin
        if (!redirect_hit && halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!redirect_hit && !halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Moore fetch output: only RUN offers the PC to fetch.
  always_comb begin
    fetch_valid = 1'b0;
    unique case (state_q)
      ST_RUN:  fetch_valid = 1'b1;
      default: fetch_valid = 1'b0;
    endcase
  end

  // PC update priority: trap, redirect, halt hold, sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (misalign_hit) begin
      pc_d = TRAP_VECTOR;
    end else if (redirect_hit) begin
      pc_d = target_pc;
    end else if (fetch_fire && !halt_req) begin
      pc_d = pc_q + INSN_BYTES;
    end
  end

  // Architectural PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc        = pc_q;
  assign redirect  = redirect_hit;
  assign link_addr = ex_pc + INSN_BYTES;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus a randomized run
// compared against a behavioural model. Builds with or without
// PC_MISALIGN_TRAP_EN; expectations follow the same macro.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready, halt_req, ex_valid;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic        ex_zero, ex_lt, ex_ltu;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic [31:0] pc, link_addr, bad_addr;
  logic        fetch_valid, redirect, misalign_exc;

  pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .halt_req(halt_req),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_zero(ex_zero),
    .ex_lt(ex_lt), .ex_ltu(ex_ltu), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .pc(pc), .fetch_valid(fetch_valid), .redirect(redirect),
    .link_addr(link_addr), .misalign_exc(misalign_exc), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: booting/halted flags, PC and captured fault address.
  bit          m_boot, m_halt;
  logic [31:0] m_pc, m_bad;
  // Comparison operands behind the ALU flags.
  logic [31:0] op_a, op_b;

  function automatic void set_operands(input logic [31:0] a, input logic [31:0] b);
    op_a    = a;
    op_b    = b;
    ex_zero = (a == b);
    ex_lt   = ($signed(a) < $signed(b));
    ex_ltu  = (a < b);
  endfunction

  function automatic void idle_inputs();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 3'b000; ex_pc = 32'h0; ex_imm = 32'h0; ex_rs1 = 32'h0;
    set_operands(32'd1, 32'd2);
  endfunction

  function automatic bit model_taken();
    if (!ex_valid) return 0;
    if (ex_is_jal || ex_is_jalr) return 1;
    if (!ex_is_branch) return 0;
    case (ex_funct3)
      3'd0: return op_a == op_b;
      3'd1: return op_a != op_b;
      3'd4: return $signed(op_a) < $signed(op_b);
      3'd5: return $signed(op_a) >= $signed(op_b);
      3'd6: return op_a < op_b;
      3'd7: return op_a >= op_b;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_target();
    if (ex_is_jalr) return (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    return ex_pc + ex_imm;
  endfunction

  function automatic bit model_redirect();
    return !m_boot && model_taken();
  endfunction

  function automatic bit model_exc();
`ifdef PC_MISALIGN_TRAP_EN
    return model_redirect() && (model_target() % 4 != 0);
`else
    return 0;
`endif
  endfunction

  // Advance one clock and move the model forward by the same step.
  task automatic tick();
    bit t;
    logic [31:0] tg, npc, nbad;
    bit nboot, nhalt;
    t = model_taken(); tg = model_target();
    npc = m_pc; nbad = m_bad; nboot = m_boot; nhalt = m_halt;
    if (m_boot) begin
      nboot = 0; nhalt = halt_req;
    end else if (t) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (tg % 4 != 0) begin npc = TV; nbad = tg; end
      else npc = tg;
`else
      npc = tg - (tg % 4);
`endif
    end else if (m_halt) begin
      nhalt = halt_req;
    end else if (halt_req) begin
      nhalt = 1;
    end else if (fetch_ready) begin
      npc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
    m_pc = npc; m_bad = nbad; m_boot = nboot; m_halt = nhalt;
  endtask

  function automatic void model_reset();
    m_boot = 1; m_halt = 0; m_pc = RV; m_bad = 32'h0;
  endfunction

  task automatic test_reset();
    idle_inputs(); fetch_ready = 1; halt_req = 0;
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h10; ex_imm = 32'h6;
    rst_n = 0; model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (pc !== RV) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RV); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b expected 0", redirect); end
    n_checks++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign_exc); end
    n_checks++; if (bad_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bad_addr: got %h expected 0", bad_addr); end
    idle_inputs();
    rst_n = 1; #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot_fetch_valid: got %b expected 0", fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fetch_valid[%0d]: got %b expected 1", i, fetch_valid); end
      n_checks++; if (pc !== 32'(i * 4) || pc !== m_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 32'(i * 4)); end
    end
  endtask

  task automatic test_stall();
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc !== 32'h8 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL stall[%0d]: got pc %h fv %b expected pc 00000008 fv 1", i, pc, fetch_valid); end
    end
    fetch_ready = 1;
    tick();
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL stall_resume: got %h expected 0000000c", pc); end
  endtask

  task automatic test_branch();
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000;
    ex_pc = 32'h40; ex_imm = -32'sd16; set_operands(32'd5, 32'd5);
    #1;
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL beq_taken_redirect: got %b expected 1", redirect); end
    tick();
    n_checks++; if (pc !== 32'h30) begin n_fail++; $display("FAIL beq_taken_pc: got %h expected 00000030", pc); end
    set_operands(32'd5, 32'd6);
    #1;
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL beq_nt_redirect: got %b expected 0", redirect); end
    tick();
    n_checks++; if (pc !== 32'h34) begin n_fail++; $display("FAIL beq_nt_pc: got %h expected 00000034", pc); end
    idle_inputs();
  endtask

  task automatic test_jalr();
    ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h80; ex_rs1 = 32'h1001; ex_imm = 32'h4;
    #1;
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL jalr_redirect: got %b expected 1", redirect); end
    n_checks++; if (link_addr !== 32'h84) begin n_fail++; $display("FAIL jalr_link: got %h expected 00000084", link_addr); end
    tick();
    n_checks++; if (pc !== 32'h1004) begin n_fail++; $display("FAIL jalr_pc: got %h expected 00001004", pc); end
    idle_inputs();
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b010; ex_pc = 32'h200; ex_imm = 32'h40;
    set_operands(32'd3, 32'd3);
    #1;
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL f010_redirect: got %b expected 0", redirect); end
    tick();
    n_checks++; if (pc !== 32'h1008) begin n_fail++; $display("FAIL f010_pc: got %h expected 00001008", pc); end
    idle_inputs();
  endtask

  task automatic test_halt();
    halt_req = 1;
    tick();
    tick();
    n_checks++; if (fetch_valid !== 1'b0 || pc !== 32'h1008) begin n_fail++; $display("FAIL halt_hold: got pc %h fv %b expected pc 00001008 fv 0", pc, fetch_valid); end
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h100; ex_imm = 32'h100;
    #1;
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL halt_redirect: got %b expected 1", redirect); end
    tick();
    n_checks++; if (pc !== 32'h200 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_redirect_pc: got pc %h fv %b expected pc 00000200 fv 0", pc, fetch_valid); end
    idle_inputs(); halt_req = 0;
    tick();
    n_checks++; if (pc !== 32'h200 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL halt_release: got pc %h fv %b expected pc 00000200 fv 1", pc, fetch_valid); end
    tick();
    n_checks++; if (pc !== 32'h204) begin n_fail++; $display("FAIL halt_resume: got %h expected 00000204", pc); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    bit exp_exc;
`ifdef PC_MISALIGN_TRAP_EN
    exp_pc = TV; exp_exc = 1;
`else
    exp_pc = 32'h14; exp_exc = 0;
`endif
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h10; ex_imm = 32'h6;
    #1;
    n_checks++; if (misalign_exc !== exp_exc) begin n_fail++; $display("FAIL misalign_exc: got %b expected %b", misalign_exc, exp_exc); end
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL misalign_redirect: got %b expected 1", redirect); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL misalign_pc: got %h expected %h", pc, exp_pc); end
    n_checks++; if (bad_addr !== (exp_exc ? 32'h16 : 32'h0)) begin n_fail++; $display("FAIL misalign_bad_addr: got %h expected %h", bad_addr, exp_exc ? 32'h16 : 32'h0); end
    n_checks++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse_end: got %b expected 0", misalign_exc); end
  endtask

  function automatic void random_inputs(input bit force_taken);
    int cls;
    idle_inputs();
    ex_valid  = force_taken ? 1'b1 : 1'($urandom_range(0, 2) != 0);
    cls       = force_taken ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
    ex_is_branch = (cls == 1); ex_is_jal = (cls == 2); ex_is_jalr = (cls == 3);
    ex_funct3 = 3'($urandom_range(0, 7));
    ex_pc     = $urandom & 32'hFFFF_FFFC;
    ex_rs1    = $urandom;
    ex_imm    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    op_a      = $urandom;
    op_b      = ($urandom_range(0, 3) == 0) ? op_a : $urandom;
    if ($urandom_range(0, 3) == 0) op_b = op_a ^ 32'h8000_0000;
    set_operands(op_a, op_b);
    fetch_ready = 1'($urandom_range(0, 3) != 0);
  endfunction

  task automatic run_random(input int cycles, input bit force_taken, input string tag);
    for (int i = 0; i < cycles; i++) begin
      random_inputs(force_taken);
      if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
      #1;
      n_checks++; if (redirect !== model_redirect()) begin n_fail++; $display("FAIL %s_redirect[%0d]: got %b expected %b", tag, i, redirect, model_redirect()); end
      n_checks++; if (link_addr !== ex_pc + 32'd4) begin n_fail++; $display("FAIL %s_link[%0d]: got %h expected %h", tag, i, link_addr, ex_pc + 32'd4); end
      n_checks++; if (misalign_exc !== model_exc()) begin n_fail++; $display("FAIL %s_misalign[%0d]: got %b expected %b", tag, i, misalign_exc, model_exc()); end
      tick();
      n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL %s_pc[%0d]: got %h expected %h", tag, i, pc, m_pc); end
      n_checks++; if (fetch_valid !== (!m_boot && !m_halt)) begin n_fail++; $display("FAIL %s_fetch_valid[%0d]: got %b expected %b", tag, i, fetch_valid, !m_boot && !m_halt); end
      n_checks++; if (bad_addr !== m_bad) begin n_fail++; $display("FAIL %s_bad_addr[%0d]: got %h expected %h", tag, i, bad_addr, m_bad); end
    end
    halt_req = 0;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    run_random(40, 1'b1, "b2b");
  endtask

  task automatic test_random();
    run_random(400, 1'b0, "rand");
  endtask

  task automatic test_reset_mid();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h300; ex_imm = 32'h2;
    rst_n = 0; model_reset();
    #1;
    n_checks++; if (pc !== RV || fetch_valid !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: got pc %h fv %b rd %b expected pc %h fv 0 rd 0", pc, fetch_valid, redirect, RV); end
    n_checks++; if (misalign_exc !== 1'b0 || bad_addr !== 32'h0) begin n_fail++; $display("FAIL midreset_exc: got exc %b bad %h expected 0 00000000", misalign_exc, bad_addr); end
    @(posedge clk); #1;
    idle_inputs(); fetch_ready = 1; halt_req = 0;
    rst_n = 1;
    tick();
    n_checks++; if (fetch_valid !== 1'b1 || pc !== RV) begin n_fail++; $display("FAIL midreset_restart: got pc %h fv %b expected pc %h fv 1", pc, fetch_valid, RV); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_jalr();
    test_halt();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
